// File: rtl/cell_rmw_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cell_rmw_ctrl_pkg
// Shared definitions for the cell read-modify-write sequencer: FSM state
// encoding, ALU operation codes and requester indices.
// No ports (package).
// -----------------------------------------------------------------------------
package cell_rmw_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        APPLY = 3'd3,
        WRITE = 3'd4
    } state_e;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    localparam logic REQ_CORE  = 1'b0;
    localparam logic REQ_DEBUG = 1'b1;

endpackage

// File: rtl/cell_rmw_ctrl_if.sv
// -----------------------------------------------------------------------------
// cell_rmw_ctrl_if
// Bundles the requester handshake, the memory port and the ALU port of the
// cell read-modify-write sequencer.
//   slave  : the sequencer side (drives *_o, samples *_i)
//   master : the environment side (requesters, memory, ALU)
// Signals:
//   req_valid_i/req_ready_o   2-bit handshake, bit 0 = core, bit 1 = debug
//   req_addr_i/op_i/cnt_i     per-requester payload
//   mem_addr_o/rd_en_o/rdata_i/wr_en_o/wdata_o   cell memory port
//   alu_data_o/alu_op_o/alu_result_i             external inc/dec ALU
//   done_o/done_id_o/result_o                    completion report
// -----------------------------------------------------------------------------
interface cell_rmw_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 4
);
    logic [1:0]             req_valid_i;
    logic [1:0]             req_ready_o;
    logic [1:0][ADDR_W-1:0] req_addr_i;
    logic [1:0]             req_op_i;
    logic [1:0][CNT_W-1:0]  req_cnt_i;

    logic [ADDR_W-1:0]      mem_addr_o;
    logic                   mem_rd_en_o;
    logic [7:0]             mem_rdata_i;
    logic                   mem_wr_en_o;
    logic [7:0]             mem_wdata_o;

    logic [7:0]             alu_data_o;
    logic                   alu_op_o;
    logic [7:0]             alu_result_i;

    logic                   done_o;
    logic                   done_id_o;
    logic [7:0]             result_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_op_i, req_cnt_i,
        input  mem_rdata_i, alu_result_i,
        output req_ready_o, mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
        output alu_data_o, alu_op_o, done_o, done_id_o, result_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_op_i, req_cnt_i,
        output mem_rdata_i, alu_result_i,
        input  req_ready_o, mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
        input  alu_data_o, alu_op_o, done_o, done_id_o, result_o
    );
endinterface

// File: rtl/cell_rmw_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a last-grant pointer. On a tie the
// requester not granted last wins; a lone requester always wins.
// Ports:
//   clk, reset   clock, synchronous active-high reset (pointer -> debug)
//   en_i         grant allowed this cycle
//   req_i[1:0]   request vector
//   gnt_o[1:0]   one-hot grant (zero when nothing is granted)
//   gnt_id_o     index of the winner (meaningful when ptr_upd_o is high)
//   ptr_upd_o    a grant is issued and the pointer moves to the winner
// -----------------------------------------------------------------------------
module rr_arb2
    import cell_rmw_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o,
    output logic       ptr_upd_o
);

    logic last_q;
    logic last_d;

    // Winner selection and next pointer value.
    always_comb begin
        gnt_id_o = REQ_CORE;
        case (req_i)
            2'b01:   gnt_id_o = REQ_CORE;
            2'b10:   gnt_id_o = REQ_DEBUG;
            2'b11:   gnt_id_o = ~last_q;
            default: gnt_id_o = REQ_CORE;
        endcase
        ptr_upd_o = en_i & (|req_i);
        if (ptr_upd_o) begin
            gnt_o  = gnt_id_o ? 2'b10 : 2'b01;
            last_d = gnt_id_o;
        end else begin
            gnt_o  = 2'b00;
            last_d = last_q;
        end
    end

    // Last-grant pointer; resets to debug so the core wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_DEBUG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cell_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// cell_rmw_ctrl
// Read-modify-write sequencer: accepts one request (cell address, inc/dec,
// repeat count), reads the cell, steps the external ALU once per repeat,
// writes the final value back and pulses done_o with the result.
// Build option: CELL_RMW_DEBUG_PORT_EN enables requester 1 (debug) and the
// round-robin arbiter; without it only the core requester is served.
// Ports:
//   clk, reset   clock, synchronous active-high reset (aborts any operation)
//   bus          cell_rmw_ctrl_if.slave (handshake, memory, ALU, completion)
// req_ready_o is combinational (same-cycle accept in IDLE); every other
// output is a register.
// -----------------------------------------------------------------------------
module cell_rmw_ctrl
    import cell_rmw_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic            clk,
    input  logic            reset,
    cell_rmw_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic              id_q, id_d;
    logic              op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              done_id_q, done_id_d;
    logic [7:0]        result_q, result_d;
    logic [7:0]        alu_data_q, alu_data_d;
    logic              alu_op_q, alu_op_d;

    logic [1:0]        gnt_s;
    logic              gnt_id_s;
    logic              accept_s;
    logic              idle_en_s;

    // A request is never granted while reset is asserted, so a requester
    // cannot see ready for a transaction that is then thrown away.
    assign idle_en_s = (state_q == IDLE) & ~reset;

`ifdef CELL_RMW_DEBUG_PORT_EN
    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en_i      (idle_en_s),
        .req_i     (bus.req_valid_i),
        .gnt_o     (gnt_s),
        .gnt_id_o  (gnt_id_s),
        .ptr_upd_o (accept_s)
    );
`else
    logic unused_dbg_s;
    assign accept_s     = idle_en_s & bus.req_valid_i[0];
    assign gnt_s        = {1'b0, accept_s};
    assign gnt_id_s     = REQ_CORE;
    assign unused_dbg_s = ^{bus.req_valid_i[1], bus.req_addr_i[1],
                            bus.req_op_i[1], bus.req_cnt_i[1]};
`endif

    assign bus.req_ready_o = gnt_s;

    // Next-state, operand latching and registered-output next values.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    id_d    = gnt_id_s;
                    op_d    = bus.req_op_i[gnt_id_s];
                    cnt_d   = bus.req_cnt_i[gnt_id_s];
                    addr_d  = bus.req_addr_i[gnt_id_s];
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                acc_d = bus.mem_rdata_i;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = WRITE;
                end else begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                acc_d = bus.alu_result_i;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = WRITE;
                end else begin
                    state_d = APPLY;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they belong to.
        rd_d      = (state_d == READ);
        wr_d      = (state_d == WRITE);
        done_d    = wr_d;
        wdata_d   = wr_d ? acc_d : wdata_q;
        result_d  = wr_d ? acc_d : result_q;
        done_id_d = wr_d ? id_q  : done_id_q;
        // The ALU operand equals the accumulator during APPLY and holds
        // its last value otherwise.
        alu_data_d = (state_d == APPLY) ? acc_d : alu_data_q;
        alu_op_d   = (state_d == APPLY) ? op_d  : alu_op_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= REQ_CORE;
            op_q       <= OP_INC;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= 8'h00;
            addr_q     <= {ADDR_W{1'b0}};
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 8'h00;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            result_q   <= 8'h00;
            alu_data_q <= 8'h00;
            alu_op_q   <= OP_INC;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            result_q   <= result_d;
            alu_data_q <= alu_data_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_rd_en_o = rd_q;
    assign bus.mem_wr_en_o = wr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.alu_data_o  = alu_data_q;
    assign bus.alu_op_o    = alu_op_q;
    assign bus.done_o      = done_q;
    assign bus.done_id_o   = done_id_q;
    assign bus.result_o    = result_q;

endmodule

// File: tb/tb_cell_rmw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cell_rmw_ctrl
// Directed bench for cell_rmw_ctrl with a cell memory model, an inc/dec ALU
// model and a scoreboard of expected completions. Sections that need the
// debug requester are compiled only with CELL_RMW_DEBUG_PORT_EN.
// -----------------------------------------------------------------------------
module tb_cell_rmw_ctrl;
    import cell_rmw_ctrl_pkg::*;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic       id;
        logic [7:0] addr;
        logic [7:0] res;
        logic [7:0] lat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   grant_cnt [2];
    logic busy = 1'b0;
    logic [7:0] mem [256];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    cell_rmw_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    cell_rmw_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External ALU: combinational +1 / -1 modulo 256.
    assign bus.alu_result_i = bus.alu_op_o ? (bus.alu_data_o - 8'd1) : (bus.alu_data_o + 8'd1);

    // Cell memory: read data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
        if (bus.mem_wr_en_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] v, input logic op, input logic [3:0] n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < int'(n); i++) r = op ? (r - 8'd1) : (r + 8'd1);
        return r;
    endfunction

    // Monitor: samples 1 ns before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (reset) begin
            busy = 1'b0;
        end else begin
            if (bus.req_ready_o != 2'b00) begin
                check("ready_only_idle", 32'(busy), 32'd0);
                check("ready_onehot", 32'($onehot(bus.req_ready_o)), 32'd1);
`ifndef CELL_RMW_DEBUG_PORT_EN
                check("ready1_tied_low", 32'(bus.req_ready_o[1]), 32'd0);
`endif
                if (bus.req_ready_o[1]) grant_cnt[1]++;
                else grant_cnt[0]++;
                busy = 1'b1;
                acc_cyc = cyc;
            end
            if (bus.mem_rd_en_o) begin
                check("read_timing", 32'(cyc - acc_cyc), 32'd1);
                if (exp_q.size() > 0) check("read_addr", 32'(bus.mem_addr_o), 32'(exp_q[0].addr));
            end
            if (bus.mem_wr_en_o || bus.done_o) begin
                check("write_with_done", 32'(bus.mem_wr_en_o), 32'(bus.done_o));
                check("done_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("done_id", 32'(bus.done_id_o), 32'(e.id));
                    check("result", 32'(bus.result_o), 32'(e.res));
                    check("wdata", 32'(bus.mem_wdata_o), 32'(e.res));
                    check("write_addr", 32'(bus.mem_addr_o), 32'(e.addr));
                    check("done_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                end
                busy = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic id, input logic [7:0] a, input logic [7:0] res, input int n);
        exp_t e;
        e.id = id; e.addr = a; e.res = res; e.lat = 8'(3 + n);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // One request from requester idx; waits for its grant, then for completion.
    task automatic do_req(input int idx, input logic [7:0] a, input logic op,
                          input logic [3:0] n, input logic [7:0] init);
        int g0;
        logic [7:0] res;
        res = model(init, op, n);
        mem[a] = init;
        push_exp(idx[0], a, res, int'(n));
        g0 = grant_cnt[idx];
        @(negedge clk);
        bus.req_valid_i[idx] = 1'b1;
        bus.req_addr_i[idx]  = a;
        bus.req_op_i[idx]    = op;
        bus.req_cnt_i[idx]   = n;
        for (int k = 0; k < 30 && grant_cnt[idx] == g0; k++) @(negedge clk);
        check("grant_seen", 32'(grant_cnt[idx] != g0), 32'd1);
        bus.req_valid_i[idx] = 1'b0;
        drain("drain");
        check("cell_value", 32'(mem[a]), 32'(res));
    endtask

    initial begin
        int g0;
        int g1;
        grant_cnt[0] = 0;
        grant_cnt[1] = 0;
        bus.req_valid_i = 2'b01;
        bus.req_addr_i  = '0;
        bus.req_op_i    = 2'b00;
        bus.req_cnt_i   = '0;
        repeat (3) @(negedge clk);

        // Reset state, with a core request pending that must not be accepted.
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_rd_en", 32'(bus.mem_rd_en_o), 32'd0);
        check("rst_wr_en", 32'(bus.mem_wr_en_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_addr", 32'(bus.mem_addr_o), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata_o), 32'd0);
        check("rst_alu_data", 32'(bus.alu_data_o), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op_o), 32'd0);
        check("rst_done_id", 32'(bus.done_id_o), 32'd0);
        check("rst_result", 32'(bus.result_o), 32'd0);
        bus.req_valid_i = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Increment three times: 0x05 -> 0x08, done at T+6.
        do_req(0, 8'h10, OP_INC, 4'd3, 8'h05);
        // Decrement through zero: 0x01 -> 0x00 -> 0xFF.
        do_req(0, 8'h11, OP_DEC, 4'd2, 8'h01);
        check("alu_op_hold", 32'(bus.alu_op_o), 32'd1);
        check("alu_data_hold", 32'(bus.alu_data_o), 32'h00);
        // Maximum repeat count with wrap: 0xF8 + 15 = 0x07.
        do_req(0, 8'h12, OP_INC, 4'd15, 8'hF8);

`ifdef CELL_RMW_DEBUG_PORT_EN
        // Plain read from the debug side: written back unchanged at T+3.
        do_req(1, 8'h22, OP_INC, 4'd0, 8'h5A);

        // Both requesters valid from reset: core, debug, core.
        reset = 1'b1;
        mem[8'h20] = 8'h40;
        mem[8'h30] = 8'h90;
        push_exp(1'b0, 8'h20, 8'h41, 1);
        push_exp(1'b1, 8'h30, 8'h8F, 1);
        push_exp(1'b0, 8'h20, 8'h42, 1);
        bus.req_addr_i[0] = 8'h20; bus.req_op_i[0] = OP_INC; bus.req_cnt_i[0] = 4'd1;
        bus.req_addr_i[1] = 8'h30; bus.req_op_i[1] = OP_DEC; bus.req_cnt_i[1] = 4'd1;
        bus.req_valid_i = 2'b11;
        repeat (2) @(negedge clk);
        g0 = grant_cnt[0];
        g1 = grant_cnt[1];
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (grant_cnt[1] - g1 >= 1) bus.req_valid_i[1] = 1'b0;
            if (grant_cnt[0] - g0 >= 2) bus.req_valid_i[0] = 1'b0;
            if (bus.req_valid_i == 2'b00 && exp_q.size() == 0 && !busy) break;
        end
        check("rr_drain", 32'(exp_q.size()), 32'd0);
        check("rr_core_grants", 32'(grant_cnt[0] - g0), 32'd2);
        check("rr_debug_grants", 32'(grant_cnt[1] - g1), 32'd1);
        check("rr_core_cell", 32'(mem[8'h20]), 32'h42);
        check("rr_debug_cell", 32'(mem[8'h30]), 32'h8F);
`else
        // Plain read from the core side.
        do_req(0, 8'h22, OP_INC, 4'd0, 8'h5A);

        // Debug held valid: never granted, core still served with id 0.
        mem[8'h77] = 8'h33;
        bus.req_valid_i[1] = 1'b1;
        bus.req_addr_i[1]  = 8'h77;
        bus.req_op_i[1]    = OP_INC;
        bus.req_cnt_i[1]   = 4'd2;
        do_req(0, 8'h13, OP_DEC, 4'd1, 8'h80);
        repeat (5) @(negedge clk);
        bus.req_valid_i[1] = 1'b0;
        check("debug_never_granted", 32'(grant_cnt[1]), 32'd0);
        check("debug_cell_untouched", 32'(mem[8'h77]), 32'h33);
`endif

        // Reset during APPLY of INC x8: no write, no done.
        mem[8'h40] = 8'h10;
        g0 = grant_cnt[0];
        @(negedge clk);
        bus.req_valid_i[0] = 1'b1;
        bus.req_addr_i[0]  = 8'h40;
        bus.req_op_i[0]    = OP_INC;
        bus.req_cnt_i[0]   = 4'd8;
        for (int k = 0; k < 30 && grant_cnt[0] == g0; k++) @(negedge clk);
        check("abort_grant_seen", 32'(grant_cnt[0] != g0), 32'd1);
        bus.req_valid_i[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_apply_alu", 32'(bus.alu_data_o), 32'h12);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort_no_write", 32'(bus.mem_wr_en_o), 32'd0);
            check("abort_no_done", 32'(bus.done_o), 32'd0);
            check("abort_alu_cleared", 32'(bus.alu_data_o), 32'd0);
        end
        reset = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_cell_untouched", 32'(mem[8'h40]), 32'h10);

        // Normal request after the abort, wrapping 0xFF -> 0x00.
        do_req(0, 8'h41, OP_INC, 4'd1, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
